ysyx_23060236_icache: RTL and testbench
=======================================

# ysyx_23060236_icache

Direct-mapped instruction cache that sits directly beside the IFU. It answers the IFU's combinational lookup (`icache_araddr` → `icache_rdata`, `icache_hit`) and absorbs the IFU's word-by-word refill stream (`icache_awaddr`, `icache_wdata`, `icache_wvalid`) after an AXI burst miss. It also provides a multi-cycle invalidate sweep for `fence.i`, driven from write-back, with a busy indication back to that stage.

## Interface
- `SET_BITS`, default 4: log2 of the number of sets (16 sets).
- Fixed geometry, not a parameter: 32-byte block of 8 × 32-bit words, 25-bit address, tag width = 25 − 5 − `SET_BITS` (16 at default).
- Ports:
  - `clock`  in  1  single clock; all state updates on its rising edge.
  - `reset`  in  1  synchronous, active-high.
  - `icache_araddr`  in  25  lookup address (byte address; bits [1:0] ignored).
  - `icache_rdata`  out  32  word at `icache_araddr`.
  - `icache_hit`  out  1  lookup hit.
  - `icache_awaddr`  in  25  refill word address (bits [1:0] ignored).
  - `icache_wdata`  in  32  refill word.
  - `icache_wvalid`  in  1  write strobe; one word per asserted cycle.
  - `fence_req`  in  1  single-cycle invalidate request.
  - `fence_busy`  out  1  invalidate sweep in progress.

## Operation
- Address split, for both ports: tag = [24:`SET_BITS`+5], index = [`SET_BITS`+4:5], word = [4:2].
- Storage:
  - data array of 2^`SET_BITS` × 8 words;
  - tag array of 2^`SET_BITS` entries;
  - valid bit per set, held in flops.
- Lookup (combinational):
  - `icache_hit` = valid[index] & (tag[index] == tag) & (state == IDLE).
  - `icache_rdata` = data[index][word] regardless of hit.
- Refill write, when `icache_wvalid`=1:
  - data[index][word] ← `icache_wdata`.
  - If word == 0: tag[index] ← tag and valid[index] ← 0, so the line is invalid for the whole refill.
  - If word == 7 and state == IDLE: valid[index] ← 1.
  - If word == 7 and state == FLUSH: valid is not set; the line stays invalid.
  - Refill words arrive in order 0..7 with no interleaving between sets. The cache does not check ordering.
- Invalidate FSM, states IDLE and FLUSH:
  - IDLE → FLUSH when `fence_req`=1; counter ← 0.
  - In FLUSH, each cycle: valid[counter] ← 0 and counter increments.
  - When counter == 2^`SET_BITS` − 1, the last set is cleared and the FSM returns to IDLE.
  - `fence_req` is ignored while in FLUSH.
- Simultaneous events:
  - Word-7 write and a sweep clear of the same set in the same cycle: the clear wins.
  - `fence_req` in the same cycle as a word-7 write in IDLE: valid is set, and the sweep clears it later.
- Reset:
  - All valid bits ← 0; state ← IDLE; counter ← 0; `fence_busy` = 0; `icache_hit` = 0.
  - Reset during FLUSH aborts the sweep; every line is still invalid.
  - Data and tag arrays are not reset.

## Timing
- Lookup latency is 0 cycles: outputs follow `icache_araddr` and the array state in the same cycle.
- A write is visible to lookups from the cycle after its edge. A same-cycle read returns the old contents.
- A line becomes hittable on the cycle after its word-7 write edge. The earliest hit after a word-0 write is 8 cycles later, for back-to-back refill words.
- `fence_busy` = (state == FLUSH):
  - rises the cycle after `fence_req`;
  - stays high exactly 2^`SET_BITS` cycles (16 at default);
  - `icache_hit` is 0 for all of those cycles.
- No backpressure: refill writes are accepted every cycle, including during FLUSH.

## Test plan
- **Reset and cold miss:** hold reset 2 cycles, release, drive araddr 0x0000040 → `icache_hit`=0 and `fence_busy`=0.
- **Refill then hit:**
  - write 8 words 0x11111100+i at awaddr 0x1234560+4i on consecutive cycles;
  - araddr 0x1234568 → hit=0 during the refill, hit=1 from the cycle after word 7, rdata=0x11111102.
- **Conflict replacement:**
  - after filling 0x1234560, refill index-equal 0x1334560;
  - hit for 0x1234560 drops the cycle after the word-0 write and never returns;
  - 0x1334560 hits after its word 7.
- **Fence sweep:**
  - fill sets 0 and 15, pulse `fence_req`;
  - `fence_busy`=1 for exactly 16 cycles starting next cycle, hit=0 throughout, both lines miss afterwards;
  - a second `fence_req` mid-sweep does not extend it.
- **Refill across fence:**
  - start a refill, assert `fence_req` at word 3, finish words 4–7 during FLUSH;
  - the line misses after `fence_busy` falls.
- **Reset mid-sweep:** assert reset on cycle 5 of FLUSH → next cycle `fence_busy`=0 and all previously valid lines miss.

Source files
------------

// File: rtl/ysyx_23060236_icache.sv
// ysyx_23060236_icache
//   Direct-mapped instruction cache beside the IFU. It has 2^SET_BITS sets
//   of 32-byte lines (8 x 32-bit words) over a 25-bit byte address.
//   - The lookup is purely combinational.
//   - The IFU streams refill words in order 0..7 into the write port.
//   - fence_req starts a multi-cycle sweep that clears every valid bit.
//
// Ports
//   clock, reset      single clock; synchronous active-high reset
//   icache_araddr     lookup byte address (bits [1:0] ignored)
//   icache_rdata      word at icache_araddr, returned whether or not it hits
//   icache_hit        lookup hit (forced low while sweeping)
//   icache_awaddr     refill word address (bits [1:0] ignored)
//   icache_wdata      refill word
//   icache_wvalid     refill strobe, one word per asserted cycle
//   fence_req         single-cycle invalidate request
//   fence_busy        invalidate sweep in progress
//
// Invalidate FSM
//   state | meaning
//   IDLE  | normal lookups; a fence_req starts a sweep
//   FLUSH | clears valid[cnt_q] each cycle; hits suppressed; fence_req ignored

module ysyx_23060236_icache #(
  parameter int SET_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [24:0] icache_araddr,
  output logic [31:0] icache_rdata,
  output logic        icache_hit,
  input  logic [24:0] icache_awaddr,
  input  logic [31:0] icache_wdata,
  input  logic        icache_wvalid,
  input  logic        fence_req,
  output logic        fence_busy
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 25 - 5 - SET_BITS;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic [SETS-1:0]     valid_q, valid_d;

  logic [31:0]         data_arr [SETS*8];
  logic [TAG_W-1:0]    tag_arr  [SETS];

  logic [TAG_W-1:0]    r_tag, w_tag;
  logic [SET_BITS-1:0] r_idx, w_idx;
  logic [2:0]          r_word, w_word;

  assign r_tag  = icache_araddr[24:SET_BITS+5];
  assign r_idx  = icache_araddr[SET_BITS+4:5];
  assign r_word = icache_araddr[4:2];
  assign w_tag  = icache_awaddr[24:SET_BITS+5];
  assign w_idx  = icache_awaddr[SET_BITS+4:5];
  assign w_word = icache_awaddr[4:2];

  // Byte-offset bits are dropped; this gathers them so they are not flagged as dangling.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_araddr[1:0], icache_awaddr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fence_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The sweep clear is applied last, so it wins over a word-7 set of the same set.
  // A line whose word 7 lands during FLUSH is never marked valid.
  always_comb begin
    valid_d = valid_q;
    if (icache_wvalid) begin
      if (w_word == 3'd0)
        valid_d[w_idx] = 1'b0;
      else if (w_word == 3'd7 && state_q == IDLE)
        valid_d[w_idx] = 1'b1;
    end
    if (state_q == FLUSH) valid_d[cnt_q] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // The data and tag arrays are not reset; the valid bits alone guard them.
  always_ff @(posedge clock) begin
    if (icache_wvalid) begin
      data_arr[{w_idx, w_word}] <= icache_wdata;
      if (w_word == 3'd0) tag_arr[w_idx] <= w_tag;
    end
  end

  assign icache_rdata = data_arr[{r_idx, r_word}];
  assign icache_hit   = valid_q[r_idx] && (tag_arr[r_idx] == r_tag) && (state_q == IDLE);
  assign fence_busy   = (state_q == FLUSH);

endmodule

// File: tb/tb_ysyx_23060236_icache.sv
module tb_ysyx_23060236_icache;

  logic        clock = 1'b0;
  logic        reset;
  logic [24:0] icache_araddr;
  logic [31:0] icache_rdata;
  logic        icache_hit;
  logic [24:0] icache_awaddr;
  logic [31:0] icache_wdata;
  logic        icache_wvalid;
  logic        fence_req;
  logic        fence_busy;

  ysyx_23060236_icache #(.SET_BITS(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .icache_araddr (icache_araddr),
    .icache_rdata  (icache_rdata),
    .icache_hit    (icache_hit),
    .icache_awaddr (icache_awaddr),
    .icache_wdata  (icache_wdata),
    .icache_wvalid (icache_wvalid),
    .fence_req     (fence_req),
    .fence_busy    (fence_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [24:0] addr;
    logic        hit;
    logic        chk_data;
    logic [31:0] data;
  } vec_t;

  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic lookup(input string name, input logic [24:0] addr, input logic hit,
                        input logic chk_data, input logic [31:0] data);
    vec_t v;
    v.name = name; v.addr = addr; v.hit = hit; v.chk_data = chk_data; v.data = data;
    icache_araddr = addr;
    sb.push_back(v);
    #1;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      chk({v.name, "_hit"}, {31'd0, icache_hit}, {31'd0, v.hit});
      if (v.chk_data) chk({v.name, "_data"}, icache_rdata, v.data);
    end
  endtask

  task automatic drive_word(input logic [24:0] base, input int i, input logic [31:0] seed);
    icache_awaddr = base + 25'(4 * i);
    icache_wdata  = seed + 32'(i);
    icache_wvalid = 1'b1;
  endtask

  task automatic fill_line(input logic [24:0] base, input logic [31:0] seed);
    for (int i = 0; i < 8; i++) begin
      drive_word(base, i, seed);
      cyc();
    end
    icache_wvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (fence_busy && n < 40) begin
      cyc();
      n++;
    end
    chk({name, "_sweep_end"}, {31'd0, fence_busy}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"conf_new_w0",      25'h1334560, 1'b1, 1'b1, 32'h22222200};
    vecs[1] = '{"conf_new_w7",      25'h133457C, 1'b1, 1'b1, 32'h22222207};
    vecs[2] = '{"conf_old_w1",      25'h1234564, 1'b0, 1'b1, 32'h22222201};
    vecs[3] = '{"conf_old_lowbits", 25'h123456B, 1'b0, 1'b1, 32'h22222202};
    vecs[4] = '{"cold_set10",       25'h1334540, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{"new_w3_lowbits",   25'h133456F, 1'b1, 1'b1, 32'h22222203};

    reset = 1'b1; icache_araddr = '0; icache_awaddr = '0; icache_wdata = '0;
    icache_wvalid = 1'b0; fence_req = 1'b0;
    cyc(); cyc();
    reset = 1'b0;

    // Reset and cold miss
    lookup("cold", 25'h0000040, 1'b0, 1'b0, 32'h0);
    chk("cold_busy", {31'd0, fence_busy}, 32'd0);

    // Refill then hit
    for (int i = 0; i < 8; i++) begin
      drive_word(25'h1234560, i, 32'h11111100);
      lookup("refill_during", 25'h1234568, 1'b0, 1'b0, 32'h0);
      cyc();
    end
    icache_wvalid = 1'b0;
    lookup("refill_done", 25'h1234568, 1'b1, 1'b1, 32'h11111102);

    // Conflict replacement, same index different tag
    for (int i = 0; i < 8; i++) begin
      drive_word(25'h1334560, i, 32'h22222200);
      if (i == 0) lookup("conf_same_cycle", 25'h1234560, 1'b1, 1'b1, 32'h11111100);
      else        lookup("conf_old_dropped", 25'h1234560, 1'b0, 1'b0, 32'h0);
      cyc();
    end
    icache_wvalid = 1'b0;
    for (int k = 0; k < 6; k++)
      lookup(vecs[k].name, vecs[k].addr, vecs[k].hit, vecs[k].chk_data, vecs[k].data);

    // Fence sweep over sets 0 and 15, with a redundant mid-sweep request
    fill_line(25'h0400000, 32'h33333300);
    fill_line(25'h00001E0, 32'h44444400);
    lookup("pre_fence_s0", 25'h0400004, 1'b1, 1'b1, 32'h33333301);
    lookup("pre_fence_s15", 25'h00001E0, 1'b1, 1'b1, 32'h44444400);
    fence_req = 1'b1;
    chk("fence_req_cycle_busy", {31'd0, fence_busy}, 32'd0);
    cyc();
    fence_req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      fence_req = (c == 5);
      chk($sformatf("sweep_busy_c%0d", c), {31'd0, fence_busy}, 32'd1);
      lookup($sformatf("sweep_nohit_c%0d", c), 25'h00001E0, 1'b0, 1'b0, 32'h0);
      cyc();
    end
    fence_req = 1'b0;
    chk("sweep_len", {31'd0, fence_busy}, 32'd0);
    lookup("post_fence_s0", 25'h0400000, 1'b0, 1'b0, 32'h0);
    lookup("post_fence_s15", 25'h00001E0, 1'b0, 1'b0, 32'h0);
    lookup("post_fence_s11", 25'h1334560, 1'b0, 1'b0, 32'h0);

    // Refill across fence: words 4..7 land in FLUSH after set 1 was already swept
    for (int i = 0; i < 8; i++) begin
      drive_word(25'h0000020, i, 32'h55555500);
      fence_req = (i == 3);
      cyc();
    end
    icache_wvalid = 1'b0;
    fence_req = 1'b0;
    wait_idle("across");
    lookup("across_miss", 25'h0000034, 1'b0, 1'b1, 32'h55555505);

    // Reset on the fifth FLUSH cycle
    fill_line(25'h0000040, 32'h66666600);
    fill_line(25'h0000180, 32'h77777700);
    lookup("pre_rst_s2", 25'h0000040, 1'b1, 1'b1, 32'h66666600);
    lookup("pre_rst_s12", 25'h0000180, 1'b1, 1'b1, 32'h77777700);
    fence_req = 1'b1;
    cyc();
    fence_req = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_busy", {31'd0, fence_busy}, 32'd0);
    lookup("rst_mid_s2", 25'h0000040, 1'b0, 1'b0, 32'h0);
    lookup("rst_mid_s12", 25'h0000180, 1'b0, 1'b0, 32'h0);

    // Cache works normally after the aborted sweep
    fill_line(25'h0000180, 32'h88888800);
    lookup("post_rst_refill", 25'h000019C, 1'b1, 1'b1, 32'h88888807);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
